// File: rtl/memory_stage.sv
// memory_stage: MEM stage, data-memory req/ack bus, load/store lanes, MEM/WB.
// Optional: `define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module memory_stage #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [4:0]      RdM,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      Funct3M,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            StallM,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [4:0]      RdW,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic            MisalignW,
  output logic [3:0]      DmemBusyCnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] CNT_MAX = 4'(MAX_WAIT);

  state_t      state;
  logic        is_load;
  logic        access;
  logic        sz_b;
  logic        sz_h;
  logic        mis;
  logic        go;
  logic [1:0]  a;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld;

  assign a       = ALUResultM[1:0];
  assign is_load = (ResultSrcM == 2'b01);
  assign access  = MemWriteM | is_load;
  assign sz_b    = (Funct3M[1:0] == 2'b00);
  assign sz_h    = (Funct3M[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign mis = access &
               ((sz_h & a[0]) |
                (~sz_b & ~sz_h & (|a)));
`else
  assign mis = 1'b0;
`endif

  assign go         = access & ~mis &
                      (state == IDLE);
  assign dmem_req   = ~reset &
                      ((state == WAIT) | go);
  assign dmem_we    = dmem_req & MemWriteM;
  assign StallM     = dmem_req & ~dmem_ack;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};

  // store byte lanes and lane-replicated data
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    if (MemWriteM) begin
      unique case (1'b1)
        sz_b: begin
          dmem_be    = 4'b0001 << a;
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        sz_h: begin
          dmem_be    = a[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // load byte/half select and sign/zero extension
  always_comb begin
    unique case (a)
      2'b00:   lb = dmem_rdata[7:0];
      2'b01:   lb = dmem_rdata[15:8];
      2'b10:   lb = dmem_rdata[23:16];
      default: lb = dmem_rdata[31:24];
    endcase
    lh = a[1] ? dmem_rdata[31:16]
              : dmem_rdata[15:0];
    unique case (1'b1)
      sz_b:    ld = {{24{~Funct3M[2] & lb[7]}}, lb};
      sz_h:    ld = {{16{~Funct3M[2] & lh[15]}}, lh};
      default: ld = dmem_rdata;
    endcase
  end

  // FSM, wait counter and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      DmemBusyCnt <= '0;
      ALUResultW  <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
      RdW         <= '0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= '0;
      MisalignW   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (go && !dmem_ack) state <= WAIT;
        WAIT: if (dmem_ack) state <= IDLE;
      endcase
      if (go)
        DmemBusyCnt <= '0;
      else if (state == WAIT &&
               DmemBusyCnt != CNT_MAX)
        DmemBusyCnt <= DmemBusyCnt + 4'd1;
      if (StallM) begin
        RegWriteW <= 1'b0;
        RdW       <= '0;
        MisalignW <= 1'b0;
      end else begin
        ALUResultW <= ALUResultM;
        ReadDataW  <= is_load ? ld : '0;
        PCPlus4W   <= PCPlus4M;
        RdW        <= RdM;
        RegWriteW  <= RegWriteM & ~mis;
        ResultSrcW <= ResultSrcM;
        MisalignW  <= mis;
      end
    end
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM outputs and drives a data-memory request/acknowledge bus.
- Generates store byte lanes and load extraction with sign/zero extension.
- Registers results into MEM/WB; asserts StallM back to the earlier stages while a memory access waits for acknowledge.

Parameters:
- XLEN, 32, datapath/address width (only 32 supported).
- MAX_WAIT, 15, wait-cycle counter saturation limit, used for the DmemBusyCnt debug output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ALUResultM  in  32  ALU result / effective address.
- WriteDataM  in  32  store data (rs2).
- PCPlus4M  in  32  PC+4 for JAL/JALR writeback.
- RdM  in  5  destination register.
- RegWriteM  in  1  register write enable.
- MemWriteM  in  1  store.
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4; 01 marks a load.
- Funct3M  in  3  access size/sign.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  access complete; dmem_rdata valid in this cycle for loads.
- dmem_rdata  in  32  read word.
- StallM  out  1  upstream must hold all *M inputs stable.
- ALUResultW, ReadDataW, PCPlus4W  out  32  MEM/WB register.
- RdW  out  5; RegWriteW  out  1; ResultSrcW  out  2.
- MisalignW  out  1  misaligned-access flag (see Optional Feature).
- DmemBusyCnt  out  4  wait cycles of the current/last access, saturating at MAX_WAIT.

Behaviour:
- Access = MemWriteM | (ResultSrcM==01).
- FSM states IDLE and WAIT.
- IDLE, no access: W register loads the *M values next edge (1-cycle latency); StallM=0.
- IDLE, access: dmem_req=1 combinationally in the same cycle. dmem_we=MemWriteM.
  - dmem_ack=1 in the same cycle: zero-wait completion; W loads next edge; StallM=0.
  - Otherwise: go to WAIT. StallM=1 in this cycle. W gets a bubble (RegWriteW=0, RdW=0).
- WAIT: dmem_req held at 1; addr/we/be/wdata held stable from the held *M inputs; StallM=1; bubble into W each cycle.
  - dmem_ack=1: StallM=0 that cycle; W captures the result; next state IDLE.
  - Back-to-back accesses re-enter WAIT the following cycle if ack is absent.
- Store lanes:
  - SB(000): be=0001<<addr[1:0]; wdata={4{rs2[7:0]}}.
  - SH(001): be=addr[1]?1100:0011; wdata={2{rs2[15:0]}}.
  - SW(010): be=1111.
  - Loads drive be=1111, dmem_we=0.
- Load extraction from dmem_rdata, using ALUResultM[1:0]:
  - LB: sign-extended byte. LBU: zero-extended byte.
  - LH: sign-extended halfword selected by addr[1]. LHU: zero-extended halfword.
  - LW: full word.
  - Funct3 011/110/111: treated as LW.
- ReadDataW holds the extended value; it is 0 for non-loads.
- DmemBusyCnt: cleared when a request starts; +1 per WAIT cycle; saturates at MAX_WAIT.
- Reset:
  - All W outputs, MisalignW and DmemBusyCnt go to 0; state goes to IDLE.
  - dmem_req, StallM and dmem_we are forced to 0 during reset.
  - Reset mid-WAIT abandons the access; an ack arriving while reset=1 is ignored.
- x0 writes pass through; the register file ignores them.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) issues no request: dmem_req=0, no stall.
  - W receives RegWriteW=0 and MisalignW=1 for one cycle; the store is suppressed.
- Undefined:
  - MisalignW is tied to 0.
  - Offending low address bits are ignored: halfword uses addr[1]; word is forced aligned.

Test Plan:
- ALU op, RdM=5, ALUResultM=0x1234, RegWriteM=1 -> next cycle ALUResultW=0x1234, RdW=5, RegWriteW=1, no dmem_req.
- SB addr=0x103, rs2=0xA5, ack same cycle -> dmem_be=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x100, StallM=0.
- LB addr=0x202, rdata=0x0080FF00, ack after 3 wait cycles -> StallM high 3 cycles, 3 bubbles, then ReadDataW=0xFFFFFF80, DmemBusyCnt=3.
- LHU addr=0x2, rdata=0x8001_0000 -> ReadDataW=0x00008001; LH on the same access -> 0xFFFF8001.
- Reset asserted in WAIT, ack arrives same cycle -> W outputs 0, dmem_req=0, IDLE next cycle.
- MISALIGN_TRAP_EN, SW addr=0x102 -> dmem_req=0, MisalignW=1 one cycle, RegWriteW=0; without the macro -> be=1111, addr=0x100.
